// File: rtl/bus_cycle_unit.sv
// bus_cycle_unit: bridges a CPU_W-wide CPU request port to a BUS_W-wide
// multiplexed address/data bus. Each CPU access is split into one or more
// beats, each using T1-T4 timing with ready-driven wait states in T3.
// Read data is assembled little-endian (beat 0 -> lane 0).
// Optional macro BUS_CYCLE_HOLD_EN adds hold/hlda bus arbitration and bus_oe.
module bus_cycle_unit #(
    parameter int ADDR_W = 20,
    parameter int CPU_W  = 16,
    parameter int BUS_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic              req_byte,
    input  logic              req_io,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [CPU_W-1:0]  req_wdata,
    output logic              req_busy,
    output logic              rsp_valid,
    output logic [CPU_W-1:0]  rsp_rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [BUS_W-1:0]  ad_o,
    output logic              ad_oe,
    input  logic [BUS_W-1:0]  ad_i,
    output logic              ale,
    output logic              rd_n,
    output logic              wr_n,
    output logic              den_n,
    output logic              dtr,
    output logic              iom,
    input  logic              ready
`ifdef BUS_CYCLE_HOLD_EN
    ,
    input  logic              hold,
    output logic              hlda,
    output logic              bus_oe
`endif
);

    localparam int BEATS  = CPU_W / BUS_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    // Reject widths the beat splitting cannot represent.
    if ((CPU_W % BUS_W) != 0 || BEATS < 1) begin : g_bad_cpu_w
        $error("bus_cycle_unit: CPU_W must be a positive multiple of BUS_W");
    end
    if (BUS_W > ADDR_W) begin : g_bad_bus_w
        $error("bus_cycle_unit: BUS_W must not exceed ADDR_W");
    end

`ifdef BUS_CYCLE_HOLD_EN
    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_T4, S_HOLD} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_T4} state_t;
`endif

    state_t              state_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [BEAT_W-1:0]   last_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [CPU_W-1:0]    wdata_q;
    logic                we_q;
    logic [CPU_W-1:0]    rdata_q;
    logic [CPU_W-1:0]    rsp_rdata_q;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic [BUS_W-1:0]    ad_o_q;
    logic                ad_oe_q, ale_q, rd_n_q, wr_n_q, den_n_q;
    logic                dtr_q, iom_q, busy_q, rsp_valid_q;

    logic                accept;
    logic [BEAT_W-1:0]   beat_d;
    logic [ADDR_W-1:0]   next_addr;
    int                  lane_lo;
    logic [BUS_W-1:0]    wr_lane;
    logic [CPU_W-1:0]    rd_merged;

    // A request is taken only in IDLE; a pending hold wins over it.
`ifdef BUS_CYCLE_HOLD_EN
    assign accept = (state_q == S_IDLE) && req_valid && !hold;
`else
    assign accept = (state_q == S_IDLE) && req_valid;
`endif

    // Beat bookkeeping: next beat/address and the lane addressed by this beat.
    always_comb begin
        beat_d    = beat_q + BEAT_W'(1);
        next_addr = addr_q + ADDR_W'(beat_d);
        lane_lo   = int'(beat_q) * BUS_W;
        wr_lane   = wdata_q[lane_lo +: BUS_W];
        rd_merged = rdata_q;
        rd_merged[lane_lo +: BUS_W] = ad_i;
    end

    // Request latch and read assembly buffer; no reset needed, both are
    // loaded on acceptance before any use.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            we_q    <= req_we;
            last_q  <= req_byte ? '0 : BEAT_W'(BEATS - 1);
            rdata_q <= '0;
        end else if (state_q == S_T3 && ready && !we_q) begin
            rdata_q <= rd_merged;
        end
    end

`ifdef BUS_CYCLE_HOLD_EN
    logic hlda_q, bus_oe_q;
    assign hlda   = hlda_q;
    assign bus_oe = bus_oe_q;
`endif

    // Bus cycle sequencer; every bus output is registered on state entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            den_n_q     <= 1'b1;
            ale_q       <= 1'b0;
            ad_oe_q     <= 1'b0;
            dtr_q       <= 1'b0;
            iom_q       <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            bus_addr_q  <= '0;
            ad_o_q      <= '0;
`ifdef BUS_CYCLE_HOLD_EN
            hlda_q      <= 1'b0;
            bus_oe_q    <= 1'b1;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
`ifdef BUS_CYCLE_HOLD_EN
                    if (hold) begin
                        state_q  <= S_HOLD;
                        busy_q   <= 1'b1;
                        hlda_q   <= 1'b1;
                        bus_oe_q <= 1'b0;
                    end else
`endif
                    if (req_valid) begin
                        state_q    <= S_T1;
                        beat_q     <= '0;
                        busy_q     <= 1'b1;
                        bus_addr_q <= req_addr;
                        ad_o_q     <= req_addr[BUS_W-1:0];
                        ad_oe_q    <= 1'b1;
                        ale_q      <= 1'b1;
                        den_n_q    <= 1'b1;
                        dtr_q      <= req_we;
                        iom_q      <= req_io;
                    end
                end
                S_T1: begin
                    state_q <= S_T2;
                    ale_q   <= 1'b0;
                    den_n_q <= 1'b0;
                    if (we_q) begin
                        wr_n_q  <= 1'b0;
                        ad_oe_q <= 1'b1;
                        ad_o_q  <= wr_lane;
                    end else begin
                        rd_n_q  <= 1'b0;
                        ad_oe_q <= 1'b0;
                    end
                end
                S_T2: begin
                    state_q <= S_T3;
                end
                S_T3: begin
                    if (ready) begin
                        state_q <= S_T4;
                        rd_n_q  <= 1'b1;
                        wr_n_q  <= 1'b1;
                        den_n_q <= 1'b1;
                        ad_oe_q <= 1'b0;
                        if (beat_q == last_q) begin
                            rsp_valid_q <= 1'b1;
                            if (!we_q) begin
                                rsp_rdata_q <= rd_merged;
                            end
                        end
                    end
                end
                S_T4: begin
                    if (beat_q != last_q) begin
                        state_q    <= S_T1;
                        beat_q     <= beat_d;
                        bus_addr_q <= next_addr;
                        ad_o_q     <= next_addr[BUS_W-1:0];
                        ad_oe_q    <= 1'b1;
                        ale_q      <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        dtr_q   <= 1'b0;
                        iom_q   <= 1'b0;
                    end
                end
`ifdef BUS_CYCLE_HOLD_EN
                S_HOLD: begin
                    if (!hold) begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        hlda_q   <= 1'b0;
                        bus_oe_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_busy  = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign bus_addr  = bus_addr_q;
    assign ad_o      = ad_o_q;
    assign ad_oe     = ad_oe_q;
    assign ale       = ale_q;
    assign rd_n      = rd_n_q;
    assign wr_n      = wr_n_q;
    assign den_n     = den_n_q;
    assign dtr       = dtr_q;
    assign iom       = iom_q;

endmodule

// File: tb/tb_bus_cycle_unit.sv
// Testbench for bus_cycle_unit: directed cases plus randomized transactions
// checked against a transaction-level expectation of the bus timing.
module tb_bus_cycle_unit;

    localparam int ADDR_W = 20;
    localparam int CPU_W  = 16;
    localparam int BUS_W  = 8;
    localparam int BEATS  = CPU_W / BUS_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_we = 1'b0;
    logic              req_byte = 1'b0;
    logic              req_io = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [CPU_W-1:0]  req_wdata = '0;
    logic [BUS_W-1:0]  ad_i = '0;
    logic              ready = 1'b0;
    logic              req_busy, rsp_valid, ad_oe, ale, rd_n, wr_n, den_n, dtr, iom;
    logic [CPU_W-1:0]  rsp_rdata;
    logic [ADDR_W-1:0] bus_addr;
    logic [BUS_W-1:0]  ad_o;
`ifdef BUS_CYCLE_HOLD_EN
    logic              hold = 1'b0;
    logic              hlda, bus_oe;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int hold_at_beat = -1;
    logic [CPU_W-1:0] exp_rdata = '0;

    bus_cycle_unit #(.ADDR_W(ADDR_W), .CPU_W(CPU_W), .BUS_W(BUS_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_byte(req_byte), .req_io(req_io), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_busy(req_busy), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .bus_addr(bus_addr), .ad_o(ad_o), .ad_oe(ad_oe),
        .ad_i(ad_i), .ale(ale), .rd_n(rd_n), .wr_n(wr_n), .den_n(den_n),
        .dtr(dtr), .iom(iom), .ready(ready)
`ifdef BUS_CYCLE_HOLD_EN
        , .hold(hold), .hlda(hlda), .bus_oe(bus_oe)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bus protocol invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rd_wr_exclusive", rd_n | wr_n, 1);
            chk("ale_vs_strobe", !(ale && !(rd_n && wr_n)), 1);
        end
    end

    // Garbage on the request port while busy must be ignored.
    task automatic junk_req();
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_byte  = 1'($urandom_range(0, 1));
        req_io    = 1'($urandom_range(0, 1));
        req_addr  = ADDR_W'($urandom);
        req_wdata = CPU_W'($urandom);
    endtask

    // One CPU transaction. rsrc supplies the bytes the bus returns (lane b in
    // beat b); wfix>=0 fixes wait states per beat, else random 0..3;
    // abort_b>=0 asserts rst in the first T3 cycle of that beat.
    task automatic do_txn(input bit we, input bit byt, input bit io,
                          input logic [ADDR_W-1:0] addr, input logic [CPU_W-1:0] wdata,
                          input logic [CPU_W-1:0] rsrc, input int wfix, input int abort_b);
        int nb, wtot, t_req, w;
        logic [ADDR_W-1:0] ba;
        logic [BUS_W-1:0]  lane;
        nb = byt ? 1 : BEATS;
        wtot = 0;
        chk("idle_busy", req_busy, 0);
        req_valid = 1'b1; req_we = we; req_byte = byt; req_io = io;
        req_addr = addr; req_wdata = wdata;
        t_req = cyc;
        step();
        junk_req();
        for (int b = 0; b < nb; b++) begin
            ba   = addr + ADDR_W'(b);
            lane = wdata[b*BUS_W +: BUS_W];
            // T1
            chk("t1_ale", ale, 1);
            chk("t1_bus_addr", bus_addr, ba);
            chk("t1_ad_o", ad_o, ba[BUS_W-1:0]);
            chk("t1_ad_oe", ad_oe, 1);
            chk("t1_strobes", {rd_n, wr_n, den_n}, 3'b111);
            chk("t1_dtr_iom", {dtr, iom}, {we, io});
            chk("t1_busy", req_busy, 1);
            chk("t1_rsp", rsp_valid, 0);
`ifdef BUS_CYCLE_HOLD_EN
            chk("t1_hlda", hlda, 0);
            chk("t1_bus_oe", bus_oe, 1);
            if (b == hold_at_beat) hold = 1'b1;
`endif
            ready = 1'($urandom_range(0, 1));
            ad_i = BUS_W'($urandom);
            step();
            // T2
            w = (wfix >= 0) ? wfix : int'($urandom_range(0, 3));
            wtot += w;
            chk("t2_ale", ale, 0);
            chk("t2_strobes", {rd_n, wr_n, den_n}, we ? 3'b100 : 3'b010);
            chk("t2_ad_oe", ad_oe, we);
            if (we) chk("t2_ad_o", ad_o, lane);
            chk("t2_dtr_iom", {dtr, iom}, {we, io});
            ready = 1'($urandom_range(0, 1));
            step();
            // T3 plus wait states
            for (int k = 0; k <= w; k++) begin
                chk("t3_strobes", {rd_n, wr_n, den_n}, we ? 3'b100 : 3'b010);
                chk("t3_ad_oe", ad_oe, we);
                if (we) chk("t3_ad_o", ad_o, lane);
                chk("t3_dtr_iom", {dtr, iom}, {we, io});
                chk("t3_rsp", rsp_valid, 0);
                if (b == abort_b) begin
                    rst = 1'b1;
                    req_valid = 1'b0;
                    #1;
                    chk("abort_strobes", {rd_n, wr_n, den_n}, 3'b111);
                    chk("abort_busy", req_busy, 0);
                    step();
                    chk("abort_strobes_next", {rd_n, wr_n, den_n, ale, ad_oe}, 5'b11100);
                    chk("abort_busy_next", req_busy, 0);
                    chk("abort_rsp", rsp_valid, 0);
                    chk("abort_rdata", rsp_rdata, 0);
                    exp_rdata = '0;
                    rst = 1'b0;
                    return;
                end
                ready = (k == w);
                ad_i = (k == w) ? rsrc[b*BUS_W +: BUS_W] : BUS_W'($urandom);
                step();
            end
            // T4
            chk("t4_strobes", {rd_n, wr_n, den_n, ale, ad_oe}, 5'b11100);
            chk("t4_dtr_iom", {dtr, iom}, {we, io});
            chk("t4_rsp", rsp_valid, (b == nb - 1));
            if (b == nb - 1) begin
                chk("latency", cyc - t_req, 4 * nb + wtot);
                if (!we) exp_rdata = byt ? CPU_W'(rsrc[BUS_W-1:0]) : rsrc;
                chk("rsp_rdata", rsp_rdata, exp_rdata);
            end
            ready = 1'($urandom_range(0, 1));
            ad_i = BUS_W'($urandom);
            step();
        end
        req_valid = 1'b0;
        // IDLE cycle after the final T4
        chk("idle_busy_after", req_busy, 0);
        chk("idle_rsp", rsp_valid, 0);
        chk("idle_rdata_held", rsp_rdata, exp_rdata);
        chk("idle_strobes", {rd_n, wr_n, den_n, ale, ad_oe}, 5'b11100);
        chk("idle_dtr_iom", {dtr, iom}, 2'b00);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [ADDR_W-1:0] a;
        rst = 1'b1;
        step();
        step();
        chk("rst_strobes", {rd_n, wr_n, den_n}, 3'b111);
        chk("rst_ctrl", {ale, ad_oe, dtr, iom, req_busy, rsp_valid}, 6'b0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_ad_o", ad_o, 0);
`ifdef BUS_CYCLE_HOLD_EN
        chk("rst_hold", {hlda, bus_oe}, 2'b01);
`endif
        rst = 1'b0;
        step();

        // Directed cases
        do_txn(1'b0, 1'b0, 1'b0, 20'h12345, 16'h0000, 16'h1234, 0, -1);
        do_txn(1'b1, 1'b0, 1'b1, 20'h00100, 16'hBEEF, 16'h5A5A, 0, -1);
        chk("write_keeps_rdata", rsp_rdata, 16'h1234);
        do_txn(1'b0, 1'b1, 1'b0, 20'h00010, 16'h0000, 16'h77A5, 3, -1);
        chk("byte_read_zero_ext", rsp_rdata, 16'h00A5);
        do_txn(1'b0, 1'b0, 1'b0, 20'hFFFFF, 16'h0000, 16'hC3D2, 0, -1);
        do_txn(1'b1, 1'b0, 1'b0, 20'h00100, 16'hBEEF, 16'h0000, 0, 1);
        do_txn(1'b0, 1'b0, 1'b1, 20'h2A000, 16'h0000, 16'h9E01, 1, -1);

`ifdef BUS_CYCLE_HOLD_EN
        hold_at_beat = 1;
        do_txn(1'b0, 1'b0, 1'b0, 20'h00004, 16'h0000, 16'h2211, 0, -1);
        hold_at_beat = -1;
        step();
        chk("hold_hlda", {hlda, bus_oe}, 2'b10);
        chk("hold_busy", req_busy, 1);
        chk("hold_bus", {rd_n, wr_n, ad_oe}, 3'b110);
        hold = 1'b0;
        step();
        chk("unhold_hlda", {hlda, bus_oe}, 2'b01);
        chk("unhold_busy", req_busy, 0);
`endif

        // Randomized transactions, sometimes back-to-back
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 7) == 0) ? 20'hFFFFF : ADDR_W'($urandom);
            do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), a, CPU_W'($urandom),
                   CPU_W'($urandom), -1, -1);
            if ($urandom_range(0, 1) == 1) begin
                ready = 1'($urandom_range(0, 1));
                step();
                chk("gap_busy", req_busy, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
